// File: rtl/cart_bs_detect.sv
// Cartridge loader supervisor: watches the ROM download byte stream, measures the image
// and picks the bank-switch scheme and SuperChip enable once the download completes.
module cart_bs_detect #(
  parameter int ADDR_W     = 17,
  parameter int SIG_3F_MIN = 2,
  parameter int SC_LEN     = 128
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [3:0]        ext_bs,
  input  logic [1:0]        sc_mode,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic [ADDR_W-1:0] rom_size,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [3:0]  SIG_3F_C = 4'(SIG_3F_MIN);
  localparam logic [11:0] SC_LEN_C = 12'(SC_LEN);

  state_t              state;
  logic                dl_prev;
  logic [ADDR_W-1:0]   max_addr;
  logic [ADDR_W-1:0]   prev_addr;
  logic                any_wr;
  logic                sc_ok;
  logic [7:0]          bank_byte;
  logic [39:0]         win;
  logic [2:0]          win_vld;
  logic [3:0]          cnt_e0;
  logic [3:0]          cnt_3f;
  logic [3:0]          cnt_fe;

  logic                dl_rise;
  logic                dl_fall;
  logic [39:0]         win_next;
  logic [2:0]          vld_next;
  logic                hit_e0;
  logic                hit_3f;
  logic                hit_fe;
  logic [ADDR_W-1:0]   sz;
  logic                has_3f;
  logic [3:0]          bs_res;
  logic                sc_res;

  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic hit);
    return (hit && (c != 4'hF)) ? c + 4'd1 : c;
  endfunction

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;

  // A gap in the address sequence restarts the signature window with just the new byte.
  always_comb begin
    win_next = {32'h0, ioctl_dout};
    vld_next = 3'd1;
    if (ioctl_addr == prev_addr + ADDR_W'(1)) begin
      win_next = {win[31:0], ioctl_dout};
      vld_next = (win_vld >= 3'd5) ? 3'd5 : win_vld + 3'd1;
    end else begin
      win_next = {32'h0, ioctl_dout};
      vld_next = 3'd1;
    end
    hit_e0 = (vld_next >= 3'd3) && (win_next[23:0] == 24'h8DE01F);
    hit_3f = (vld_next >= 3'd2) && (win_next[15:0] == 16'h853F);
    hit_fe = (vld_next == 3'd5) && (win_next == 40'h2000D0C6C5);
  end

  always_comb begin
    sz     = any_wr ? max_addr + ADDR_W'(1) : '0;
    has_3f = (cnt_3f >= SIG_3F_C);
    if (ext_bs != 4'd0) begin
      bs_res = ext_bs;
    end else if (sz <= ADDR_W'(4096)) begin
      bs_res = 4'd0;
    end else if (sz == ADDR_W'(8192)) begin
      if (has_3f)               bs_res = 4'd5;
      else if (cnt_e0 != 4'd0)  bs_res = 4'd4;
      else if (cnt_fe != 4'd0)  bs_res = 4'd3;
      else                      bs_res = 4'd1;
    end else if ((sz >= ADDR_W'(10240)) && (sz <= ADDR_W'(10495))) begin
      bs_res = 4'd7;
    end else if (sz == ADDR_W'(12288)) begin
      bs_res = 4'd8;
    end else if (sz == ADDR_W'(16384)) begin
      bs_res = has_3f ? 4'd5 : 4'd2;
    end else if (sz == ADDR_W'(32768)) begin
      bs_res = has_3f ? 4'd5 : 4'd6;
    end else begin
      bs_res = has_3f ? 4'd5 : 4'd0;
    end
    case (sc_mode)
      2'd0:    sc_res = sc_ok && (sz >= ADDR_W'(8192));
      2'd1:    sc_res = 1'b0;
      default: sc_res = 1'b1;
    endcase
  end

  // Control FSM; a download rise restarts the scan from any state, even mid-RESOLVE.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= IDLE;
      dl_prev   <= ioctl_download;
      max_addr  <= '0;
      prev_addr <= '0;
      any_wr    <= 1'b0;
      sc_ok     <= 1'b1;
      bank_byte <= 8'h00;
      win       <= 40'h0;
      win_vld   <= 3'd0;
      cnt_e0    <= 4'd0;
      cnt_3f    <= 4'd0;
      cnt_fe    <= 4'd0;
      force_bs  <= 4'd0;
      sc        <= 1'b0;
      rom_size  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      done    <= 1'b0;
      if (dl_rise) begin
        state    <= LOAD;
        max_addr <= '0;
        any_wr   <= 1'b0;
        sc_ok    <= 1'b1;
        win_vld  <= 3'd0;
        cnt_e0   <= 4'd0;
        cnt_3f   <= 4'd0;
        cnt_fe   <= 4'd0;
        busy     <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (ioctl_wr) begin
              if (ioctl_addr > max_addr) max_addr <= ioctl_addr;
              any_wr    <= 1'b1;
              prev_addr <= ioctl_addr;
              win       <= win_next;
              win_vld   <= vld_next;
              cnt_e0    <= sat_inc(cnt_e0, hit_e0);
              cnt_3f    <= sat_inc(cnt_3f, hit_3f);
              cnt_fe    <= sat_inc(cnt_fe, hit_fe);
              if (ioctl_addr[11:0] == 12'd0) begin
                bank_byte <= ioctl_dout;
              end else if ((ioctl_addr[11:0] < SC_LEN_C) && (ioctl_dout != bank_byte)) begin
                sc_ok <= 1'b0;
              end
            end
            if (dl_fall) state <= RESOLVE;
          end
          RESOLVE: begin
            force_bs <= bs_res;
            sc       <= sc_res;
            rom_size <= sz;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_bs_detect.sv
// Directed bench for cart_bs_detect: loads several images and checks the resolved scheme,
// SuperChip flag, size, handshake timing, reset mid-load and re-raise during RESOLVE.
module tb_cart_bs_detect;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [16:0] ioctl_addr = 17'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [3:0]  ext_bs = 4'd0;
  logic [1:0]  sc_mode = 2'd0;
  logic [3:0]  force_bs;
  logic        sc;
  logic [16:0] rom_size;
  logic        busy;
  logic        done;

  int passed = 0;
  int total = 0;
  int fails = 0;
  int done_cnt = 0;
  int dc;

  cart_bs_detect dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ext_bs(ext_bs), .sc_mode(sc_mode), .force_bs(force_bs), .sc(sc),
    .rom_size(rom_size), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    ioctl_addr = 17'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] d);
    for (int a = lo; a <= hi; a++) wr(a, d);
  endtask

  task automatic start_dl(input string tag);
    ioctl_download = 1'b1;
    tick();
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_dl(input string tag, input int e_bs, input int e_sc, input int e_sz);
    int n;
    n = 0;
    ioctl_download = 1'b0;
    do begin
      tick();
      n++;
    end while ((done !== 1'b1) && (n < 8));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_force_bs"}, 32'(force_bs), 32'(e_bs));
    chk({tag, "_sc"}, 32'(sc), 32'(e_sc));
    chk({tag, "_rom_size"}, 32'(rom_size), 32'(e_sz));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_force_bs", 32'(force_bs), 32'd0);
    chk("rst_sc", 32'(sc), 32'd0);
    chk("rst_rom_size", 32'(rom_size), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // 4K of 0xEA
    start_dl("t4k");
    fill(0, 4095, 8'hEA);
    finish_dl("t4k", 0, 0, 4096);

    // 8K with contiguous 8D E0 1F -> E0
    start_dl("te0");
    fill(0, 16'h00FF, 8'h00);
    wr(16'h0100, 8'h8D); wr(16'h0101, 8'hE0); wr(16'h0102, 8'h1F);
    fill(16'h0103, 16'h1FFF, 8'h00);
    finish_dl("te0", 4, 1, 8192);

    // same bytes split by an address jump -> F8
    start_dl("tsplit");
    fill(0, 16'h00FF, 8'h00);
    wr(16'h0100, 8'h8D); wr(16'h0102, 8'hE0); wr(16'h0103, 8'h1F);
    fill(16'h0104, 16'h1FFF, 8'h00);
    finish_dl("tsplit", 1, 1, 8192);

    // 32K, first 128 bytes of every bank 0xFF
    for (int m = 0; m < 2; m++) begin
      sc_mode = 2'(m);
      start_dl(m == 0 ? "tsc_auto" : "tsc_off");
      for (int b = 0; b < 8; b++) fill(b * 4096, b * 4096 + 127, 8'hFF);
      wr(16'h7FFF, 8'h00);
      finish_dl(m == 0 ? "tsc_auto" : "tsc_off", 6, (m == 0) ? 1 : 0, 32768);
    end
    sc_mode = 2'd0;

    // extension override
    ext_bs = 4'd9;
    start_dl("text");
    fill(0, 2047, 8'h00);
    finish_dl("text", 9, 0, 2048);
    ext_bs = 4'd0;

    // two 85 3F hits -> 3F
    start_dl("t3f");
    fill(0, 16'h01FF, 8'h00);
    wr(16'h0200, 8'h85); wr(16'h0201, 8'h3F);
    fill(16'h0202, 16'h02FF, 8'h00);
    wr(16'h0300, 8'h85); wr(16'h0301, 8'h3F);
    fill(16'h0302, 16'h1FFF, 8'h00);
    finish_dl("t3f", 5, 1, 8192);

    // size boundaries using sparse writes
    start_dl("tp2_lo"); wr(10239, 8'h00); finish_dl("tp2_lo", 7, 1, 10240);
    start_dl("tp2_hi"); wr(10494, 8'h00); finish_dl("tp2_hi", 7, 1, 10495);
    start_dl("tp2_out"); wr(10495, 8'h00); finish_dl("tp2_out", 0, 1, 10496);
    start_dl("tfa"); wr(12287, 8'h00); finish_dl("tfa", 8, 1, 12288);

    // reset in the middle of an 8K load
    start_dl("trst");
    fill(0, 2999, 8'hAA);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    dc = done_cnt;
    chk("trst_force_bs", 32'(force_bs), 32'd0);
    chk("trst_sc", 32'(sc), 32'd0);
    chk("trst_rom_size", 32'(rom_size), 32'd0);
    chk("trst_busy", 32'(busy), 32'd0);
    chk("trst_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("trst_no_done", 32'(done_cnt), 32'(dc));

    // full 16K after reset -> F6, one done pulse
    dc = done_cnt;
    start_dl("t16k");
    fill(0, 16383, 8'h00);
    finish_dl("t16k", 2, 1, 16384);
    tick(); tick();
    chk("t16k_done_count", 32'(done_cnt), 32'(dc + 1));

    // download re-raised during RESOLVE: first image (3F) must be ignored
    dc = done_cnt;
    start_dl("trr");
    fill(0, 16'h000F, 8'h00);
    wr(16'h0010, 8'h85); wr(16'h0011, 8'h3F);
    wr(16'h0020, 8'h85); wr(16'h0021, 8'h3F);
    fill(16'h0022, 16'h1FFF, 8'h00);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    chk("trr_busy_hold", 32'(busy), 32'd1);
    chk("trr_no_done", 32'(done), 32'd0);
    chk("trr_prev_bs", 32'(force_bs), 32'd2);
    fill(0, 16'h1FFF, 8'h00);
    finish_dl("trr", 1, 1, 8192);
    tick();
    chk("trr_done_count", 32'(done_cnt), 32'(dc + 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
